piso_serializer: RTL and testbench

Parallel-in/serial-out stage that sits directly downstream of the 4-bit parallel-load register. It accepts one WIDTH-bit word per valid/ready handshake and shifts it out MSB-first, one bit per advance cycle, under control of a downstream enable. The block signals completion with a one-cycle `done` pulse and can optionally append an even-parity bit.

---
 rtl/piso_pkg.sv | 19 +
 rtl/piso_bit_counter.sv | 28 ++
 rtl/piso_serializer.sv | 125 ++++++++++++
 tb/tb_piso_serializer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer: state encoding and default width.
// The PAR state only exists when PISO_PARITY_EN is defined.
package piso_pkg;

  localparam int PISO_WIDTH_DEF = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_PAR   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
`ifdef PISO_PARITY_EN
    ST_PAR   = S_PAR,
`endif
    ST_SHIFT = S_SHIFT
  } piso_state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer; flags the final data bit of a word.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer, MSB first, valid/ready load and ser_en advance.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  piso_state_e      state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic             accept, advance, finish, last;

`ifdef PISO_PARITY_EN
  logic par;

  function automatic logic even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  // Parity is a data register captured with the word; it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) par <= even_par(par_in);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_valid) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ser_en) begin
          advance = 1'b1;
          if (last) begin
`ifdef PISO_PARITY_EN
            state_nxt = ST_PAR;
`else
            state_nxt = ST_IDLE;
            finish    = 1'b1;
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      ST_PAR: begin
        if (ser_en) begin
          state_nxt = ST_IDLE;
          finish    = 1'b1;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counter stops on the last bit instead of wrapping back to zero.
  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  (advance && !last),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg       <= '0;
      load_ready <= 1'b1;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        sreg       <= par_in;
        load_ready <= 1'b0;
        busy       <= 1'b1;
        ser_valid  <= 1'b1;
        ser_out    <= par_in[WIDTH-1];
      end else if (advance) begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
        if (!last) begin
          ser_out <= sreg[WIDTH-2];
        end
`ifdef PISO_PARITY_EN
        else begin
          ser_out <= par;
        end
`endif
      end
      // Word complete: later assignment overrides the shift update above.
      if (finish) begin
        load_ready <= 1'b1;
        busy       <= 1'b0;
        ser_valid  <= 1'b0;
        ser_out    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized bench for piso_serializer against a frame-queue reference model.
// Honors PISO_PARITY_EN to match the build under test.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] par_in = '0;
  logic         load_valid = 1'b0;
  logic         ser_en = 1'b0;
  logic         load_ready, ser_out, ser_valid, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: remaining frame bits, busy flag, done pulse
  bit q[$];
  bit m_busy = 1'b0;
  bit m_done = 1'b0;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .par_in     (par_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .ser_en     (ser_en),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic lv, input logic [W-1:0] p, input logic en);
    m_done = 1'b0;
    if (r) begin
      m_busy = 1'b0;
      q.delete();
    end else if (!m_busy) begin
      if (lv) begin
        for (int i = W - 1; i >= 0; i--) q.push_back(p[i]);
`ifdef PISO_PARITY_EN
        q.push_back(^p);
`endif
        m_busy = 1'b1;
      end
    end else if (en) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic lv, input logic [W-1:0] p, input logic en);
    rst        = r;
    load_valid = lv;
    par_in     = p;
    ser_en     = en;
    @(posedge clk);
    model_edge(r, lv, p, en);
    cyc++;
    #1;
    chk("load_ready", 32'(load_ready), 32'(!m_busy));
    chk("busy",       32'(busy),       32'(m_busy));
    chk("ser_valid",  32'(ser_valid),  32'(m_busy));
    chk("ser_out",    32'(ser_out),    32'(m_busy ? q[0] : 1'b0));
    chk("done",       32'(done),       32'(m_done));
  endtask

  logic [W-1:0] word;

  initial begin
    // Reset state
    cycle(1, 0, '0, 0);
    cycle(1, 0, '0, 1);

    // Basic shift of 0010, bits gathered independently of the model
    cycle(0, 1, 4'b0010, 1);
    word = '0;
    for (int i = 0; i < W; i++) begin
      word = {word[W-2:0], ser_out};
      cycle(0, 0, '0, 1);
    end
    chk("word_0010", 32'(word), 32'h2);
`ifdef PISO_PARITY_EN
    cycle(0, 0, '0, 1);
`endif
    cycle(0, 0, '0, 0);

    // Stall after first bit
    cycle(0, 1, 4'b1000, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 0);
    for (int i = 0; i < W + 2; i++) cycle(0, 0, '0, 1);

    // Busy rejection: 1010 held across the whole word of 0110
    cycle(0, 1, 4'b0110, 1);
    for (int i = 0; i < W + 3; i++) cycle(0, 1, 4'b1010, 1);
    for (int i = 0; i < W + 2; i++) cycle(0, 0, '0, 1);

    // Parity-relevant words
    cycle(0, 1, 4'b1100, 1);
    for (int i = 0; i < W + 2; i++) cycle(0, 0, '0, 1);
    cycle(0, 1, 4'b1000, 1);
    for (int i = 0; i < W + 2; i++) cycle(0, 0, '0, 1);

    // Reset mid-word, then a fresh load
    cycle(0, 1, 4'b1111, 1);
    cycle(0, 0, '0, 1);
    cycle(0, 0, '0, 1);
    cycle(1, 0, '0, 1);
    cycle(0, 0, '0, 1);
    cycle(0, 1, 4'b1001, 1);
    for (int i = 0; i < W + 2; i++) cycle(0, 0, '0, 1);

    // Reset coincident with a load request
    cycle(1, 1, 4'b0101, 1);
    cycle(0, 0, '0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 1) == 1),
            W'($urandom),
            ($urandom_range(0, 9) < 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
